// File: rtl/aud_pkg.sv
// Shared types and constants for the I2S DAC transmitter.
// FSM encoding and frame constants live here.
package aud_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int I2S_DELAY  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_L,
    S_LEFT,
    S_WAIT_R,
    S_RIGHT
  } aud_state_e;

endpackage

// File: rtl/aud_edge_sync.sv
// Synchroniser plus history flop for one asynchronous codec clock.
// Level and edge outputs are registered together so they stay aligned.
module aud_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_now;

  assign w_now = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_hist <= w_now;
      r_rise <= w_now & ~r_hist;
      r_fall <= r_hist & ~w_now;
    end
  end

  assign o_level = r_hist;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/aud_i2s_tx.sv
// Mono I2S transmitter for the WM8731 DAC path.
// Latches one sample per frame and sends it on both channels.
module aud_i2s_tx
  import aud_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_bclk,
  input  logic              i_daclrck,
  input  logic [DATA_W-1:0] i_dac_data,
  output logic              o_aud_dacdat,
  output logic              o_sample_req,
  output logic              o_busy
);

  localparam int CW = $clog2(DATA_W + 1);
  // counter starts at the delay slot and ends after the last data bit
  localparam logic [CW-1:0] CNT0 = CW'(I2S_DELAY - 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W + I2S_DELAY - 1);

  aud_state_e        r_state;
  aud_state_e        w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] w_hold_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              r_dat;
  logic              w_dat_nxt;
  logic              r_req;
  logic              w_req_nxt;
  logic              r_lrck_prev;
  logic              w_prev_nxt;

  logic w_bclk_fall;
  logic w_lrck;
  logic w_left_start;
  logic w_right_start;
  logic w_go_left;
  logic w_go_right;
  logic w_unused_bclk_lvl;
  logic w_unused_bclk_rise;
  logic w_unused_lrck_rise;
  logic w_unused_lrck_fall;

  aud_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bclk (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_pin   (i_bclk),
    .o_level (w_unused_bclk_lvl),
    .o_rise  (w_unused_bclk_rise),
    .o_fall  (w_bclk_fall)
  );

  aud_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lrck (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_pin   (i_daclrck),
    .o_level (w_lrck),
    .o_rise  (w_unused_lrck_rise),
    .o_fall  (w_unused_lrck_fall)
  );

  assign w_left_start  = ~w_lrck & r_lrck_prev;
  assign w_right_start = w_lrck & ~r_lrck_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_dat       <= 1'b0;
      r_req       <= 1'b0;
      r_lrck_prev <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_hold      <= w_hold_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dat       <= w_dat_nxt;
      r_req       <= w_req_nxt;
      r_lrck_prev <= w_prev_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_hold_nxt  = r_hold;
    w_cnt_nxt   = r_cnt;
    w_dat_nxt   = r_dat;
    w_req_nxt   = 1'b0;
    w_prev_nxt  = r_lrck_prev;
    w_go_left   = 1'b0;
    w_go_right  = 1'b0;
    if (w_bclk_fall) begin
      w_prev_nxt = w_lrck;
      unique case (r_state)
        S_IDLE: begin
          w_dat_nxt = 1'b0;
          if (i_en) w_state_nxt = S_WAIT_L;
        end
        S_WAIT_L: begin
          if (!i_en) w_state_nxt = S_IDLE;
          else       w_go_left   = w_left_start;
        end
        S_WAIT_R: begin
          if (!i_en) w_state_nxt = S_IDLE;
          else       w_go_right  = w_right_start;
        end
        S_LEFT, S_RIGHT: begin
          // a new lrck edge cuts a short channel word off
          if (w_left_start || w_right_start) begin
            if (!i_en) begin
              w_dat_nxt   = 1'b0;
              w_state_nxt = S_IDLE;
            end else begin
              w_go_left  = w_left_start;
              w_go_right = w_right_start;
            end
          end else if (r_cnt == LAST) begin
            w_dat_nxt = 1'b0;
            if (!i_en)                w_state_nxt = S_IDLE;
            else if (r_state == S_LEFT) w_state_nxt = S_WAIT_R;
            else                      w_state_nxt = S_WAIT_L;
          end else begin
            w_dat_nxt   = r_shift[DATA_W-1];
            w_shift_nxt = r_shift << 1;
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_go_left) begin
        w_hold_nxt  = i_dac_data;
        w_shift_nxt = i_dac_data;
        w_req_nxt   = 1'b1;
        w_cnt_nxt   = CNT0;
        w_dat_nxt   = 1'b0;
        w_state_nxt = S_LEFT;
      end
      if (w_go_right) begin
        w_shift_nxt = r_hold;
        w_cnt_nxt   = CNT0;
        w_dat_nxt   = 1'b0;
        w_state_nxt = S_RIGHT;
      end
    end
  end

  assign o_aud_dacdat = r_dat;
  assign o_sample_req = r_req;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_aud_i2s_tx.sv
// Bench for aud_i2s_tx: drives codec clocks, scoreboards DACDAT per slot.
// Also tracks sample requests per frame and outputs around reset/enable.
module tb_aud_i2s_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        bclk;
  logic        lrck;
  logic [15:0] data;
  logic        dacdat;
  logic        req;
  logic        busy;

  int   n_chk    = 0;
  int   n_err    = 0;
  int   req_cnt  = 0;
  int   req_base = 0;
  int   req_wide = 0;
  logic req_q    = 1'b0;
  logic exp_q[$];

  aud_i2s_tx #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_bclk       (bclk),
    .i_daclrck    (lrck),
    .i_dac_data   (data),
    .o_aud_dacdat (dacdat),
    .o_sample_req (req),
    .o_busy       (busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (req) req_cnt++;
    if (req && req_q) req_wide++;
    req_q = req;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic run_slots(input logic lr, input int first, input int last,
                           input logic valid, input logic [15:0] word);
    logic e;
    for (int i = first; i <= last; i++) begin
      bclk = 1'b0;
      lrck = lr;
      e = (valid && i >= 1 && i <= 16) ? word[16-i] : 1'b0;
      exp_q.push_back(e);
      #320;
      chk($sformatf("dat_%s%0d", lr ? "R" : "L", i),
          {31'd0, dacdat}, {31'd0, exp_q.pop_front()});
      bclk = 1'b1;
      #320;
    end
  endtask

  task automatic frame(input int bpc, input logic [15:0] w);
    run_slots(1'b0, 0, bpc - 1, 1'b1, w);
    run_slots(1'b1, 0, bpc - 1, 1'b1, w);
  endtask

  task automatic chk_req(input string tag, input int exp);
    chk(tag, req_cnt - req_base, exp);
    req_base = req_cnt;
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    bclk = 1'b1;
    lrck = 1'b1;
    data = 16'hA5C3;
    repeat (4) @(negedge clk);
    chk("rst_dat", {31'd0, dacdat}, 0);
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;

    // enable while lrck is high: nothing until next left start
    run_slots(1'b0, 0, 15, 1'b0, 16'h0);
    run_slots(1'b1, 0, 7, 1'b0, 16'h0);
    chk("idle_busy", {31'd0, busy}, 0);
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_busy0", {31'd0, busy}, 0);
    run_slots(1'b1, 8, 8, 1'b0, 16'h0);
    chk("en_busy1", {31'd0, busy}, 1);
    run_slots(1'b1, 9, 31, 1'b0, 16'h0);
    chk_req("req_mid", 0);
    frame(32, 16'hA5C3);
    chk_req("req_f1", 1);
    frame(32, 16'hA5C3);
    chk_req("req_f2", 1);

    // short frames
    data = 16'h1234;
    frame(16, 16'h1234);
    chk_req("req_s1", 1);
    frame(16, 16'h1234);
    chk_req("req_s2", 1);

    // data change after latch
    data = 16'h7FFF;
    run_slots(1'b0, 0, 7, 1'b1, 16'h7FFF);
    data = 16'h8000;
    run_slots(1'b0, 8, 31, 1'b1, 16'h7FFF);
    run_slots(1'b1, 0, 31, 1'b1, 16'h7FFF);
    chk_req("req_d1", 1);
    frame(32, 16'h8000);
    chk_req("req_d2", 1);

    // enable drop during bit 5 of left
    data = 16'hC3A5;
    run_slots(1'b0, 0, 10, 1'b1, 16'hC3A5);
    en = 1'b0;
    run_slots(1'b0, 11, 31, 1'b1, 16'hC3A5);
    chk("drop_busy", {31'd0, busy}, 0);
    run_slots(1'b1, 0, 19, 1'b0, 16'h0);
    chk("drop_busy2", {31'd0, busy}, 0);
    en = 1'b1;
    run_slots(1'b1, 20, 31, 1'b0, 16'h0);
    chk_req("req_drop", 1);

    // reset pulse mid-right
    data = 16'hFFFF;
    run_slots(1'b0, 0, 31, 1'b1, 16'hFFFF);
    run_slots(1'b1, 0, 9, 1'b1, 16'hFFFF);
    chk("pre_rst_dat", {31'd0, dacdat}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_dat", {31'd0, dacdat}, 0);
    chk("mid_rst_req", {31'd0, req}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    run_slots(1'b1, 10, 31, 1'b0, 16'h0);
    chk_req("req_rst", 1);
    data = 16'h0F0F;
    frame(32, 16'h0F0F);
    chk_req("req_after", 1);

    chk("req_wide", req_wide, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
